// File: rtl/pipe_pkg.sv
// pipe_pkg: forwarding selects and pipeline shadow record types
package pipe_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef logic [REG_AW-1:0] reg_t;

    typedef struct packed {
        logic v;
        reg_t rs;
        reg_t rt;
        logic use_rs;
        logic use_rt;
        reg_t dst;
        logic wr;
        logic load;
    } ex_rec_t;

    typedef struct packed {
        logic v;
        reg_t dst;
        logic wr;
        logic load;
    } mem_rec_t;

    typedef struct packed {
        logic v;
        reg_t dst;
        logic wr;
    } wb_rec_t;

    // A stage only matters when it will really write a register other than $0
    function automatic logic pending(input logic v, input logic wr, input reg_t dst);
        return v && wr && dst != '0;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at its maximum value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         inc,
    output logic [W-1:0] q
);
    // Count up on inc, hold once all ones
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the five-stage pipeline
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    ex_rec_t  ex;
    mem_rec_t mem;
    wb_rec_t  wb;
    reg_t rs, rt, dst;
    logic use_a, use_b, pend_ex, pend_mem, pend_wb;
    logic raw_ex, raw_mem, raw_wb, stall, flush;

    assign rs = REG_AW'(id_rs);
    assign rt = REG_AW'(id_rt);
    assign dst = REG_AW'(id_dst);

    // Hazard detection; the stall window widens to EX, MEM and WB when there is no forwarding
    always_comb begin
        use_a = id_valid && id_use_rs;
        use_b = id_valid && id_use_rt;
        pend_ex = pending(ex.v, ex.wr, ex.dst);
        pend_mem = pending(mem.v, mem.wr, mem.dst);
        pend_wb = pending(wb.v, wb.wr, wb.dst);
        raw_ex = pend_ex && ((use_a && rs == ex.dst) || (use_b && rt == ex.dst));
        raw_mem = pend_mem && ((use_a && rs == mem.dst) || (use_b && rt == mem.dst));
        raw_wb = pend_wb && ((use_a && rs == wb.dst) || (use_b && rt == wb.dst));
        stall = (FWD_EN != 0) ? (raw_ex && ex.load) : (raw_ex || raw_mem || raw_wb);
        flush = RSTn && ex_redirect;
        pc_en = !stall || flush;
        ifid_en = !stall || flush;
        ifid_flush = flush;
        idex_bubble = stall || flush;
    end

    // ALU operand selects: the younger result in MEM wins over WB
    always_comb begin
        fwd_a = (FWD_EN == 0 || !ex.v || !ex.use_rs) ? FWD_RF :
                (pend_mem && mem.dst == ex.rs) ? FWD_EXMEM :
                (pend_wb && wb.dst == ex.rs) ? FWD_MEMWB : FWD_RF;
        fwd_b = (FWD_EN == 0 || !ex.v || !ex.use_rt) ? FWD_RF :
                (pend_mem && mem.dst == ex.rt) ? FWD_EXMEM :
                (pend_wb && wb.dst == ex.rt) ? FWD_MEMWB : FWD_RF;
    end

    // Shadow records advance every edge; a bubble enters EX as an invalid record
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            ex <= '0;
            mem <= '0;
            wb <= '0;
        end else begin
            ex <= '{v: id_valid && !idex_bubble, rs: rs, rt: rt, use_rs: id_use_rs,
                    use_rt: id_use_rt, dst: dst, wr: id_wr, load: id_load};
            mem <= '{v: ex.v, dst: ex.dst, wr: ex.wr, load: ex.load};
            wb <= '{v: mem.v, dst: mem.dst, wr: mem.wr};
        end

    sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .RSTn(RSTn), .inc(stall && !flush), .q(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush (.CLK(CLK), .RSTn(RSTn), .inc(flush), .q(flush_cnt));
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of forwarding, stall-only and saturating-counter variants
module tb_hazard_unit;
    logic CLK = 0, RSTn = 0;
    logic id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_wr = 0, id_load = 0, ex_redirect = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_dst = 0;
    logic f_pc, f_ifen, f_ifl, f_bub, n_pc, n_ifen, n_ifl, n_bub, s_pc, s_ifen, s_ifl, s_bub;
    logic [1:0] f_fa, f_fb, n_fa, n_fb, s_fa, s_fb;
    logic [15:0] f_sc, f_fc, n_sc, n_fc;
    logic [1:0] s_sc, s_fc;
    int errors = 0, checks = 0;

    always #5 CLK = ~CLK;

    hazard_unit #(.AW(5), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_wr(id_wr),
        .id_load(id_load), .ex_redirect(ex_redirect), .pc_en(f_pc), .ifid_en(f_ifen),
        .ifid_flush(f_ifl), .idex_bubble(f_bub), .fwd_a(f_fa), .fwd_b(f_fb),
        .stall_cnt(f_sc), .flush_cnt(f_fc));

    hazard_unit #(.AW(5), .FWD_EN(0), .CNT_W(16)) u_nof (
        .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_wr(id_wr),
        .id_load(id_load), .ex_redirect(ex_redirect), .pc_en(n_pc), .ifid_en(n_ifen),
        .ifid_flush(n_ifl), .idex_bubble(n_bub), .fwd_a(n_fa), .fwd_b(n_fb),
        .stall_cnt(n_sc), .flush_cnt(n_fc));

    hazard_unit #(.AW(5), .FWD_EN(1), .CNT_W(2)) u_sat (
        .CLK(CLK), .RSTn(RSTn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_wr(id_wr),
        .id_load(id_load), .ex_redirect(ex_redirect), .pc_en(s_pc), .ifid_en(s_ifen),
        .ifid_flush(s_ifl), .idex_bubble(s_bub), .fwd_a(s_fa), .fwd_b(s_fb),
        .stall_cnt(s_sc), .flush_cnt(s_fc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dst, input logic wr, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_dst = dst; id_wr = wr; id_load = ld;
        #1;
    endtask

    task automatic nop;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RSTn = 0;
        ex_redirect = 0;
        nop();
        tick();
        RSTn = 1;
        #1;
    endtask

    initial begin
        nop();
        chk("rst_pc_en", f_pc, 1);
        chk("rst_ifid_en", f_ifen, 1);
        chk("rst_ifid_flush", f_ifl, 0);
        chk("rst_bubble", f_bub, 0);
        chk("rst_fwd", {f_fa, f_fb}, 0);
        chk("rst_cnt", {f_sc, f_fc}, 0);
        do_reset();

        set_id(1, 9, 0, 1, 0, 8, 1, 1);
        chk("lu_pre_pc", f_pc, 1);
        tick();
        set_id(1, 8, 11, 1, 1, 10, 1, 0);
        chk("lu_pc_en", f_pc, 0);
        chk("lu_ifid_en", f_ifen, 0);
        chk("lu_bubble", f_bub, 1);
        chk("lu_ifid_flush", f_ifl, 0);
        tick();
        chk("lu_release_pc", f_pc, 1);
        chk("lu_release_bub", f_bub, 0);
        chk("lu_stall_cnt", f_sc, 1);
        tick();
        nop();
        chk("lu_fwd_a", f_fa, 2'b01);
        chk("lu_fwd_b", f_fb, 2'b00);

        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0);
        chk("alu_no_stall", f_pc, 1);
        tick();
        nop();
        chk("alu_fwd_exmem", {f_fa, f_fb}, 4'b1010);
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 6, 7, 1, 1, 5, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0);
        tick();
        nop();
        chk("alu_fwd_memwb", {f_fa, f_fb}, 4'b0101);
        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 3, 0, 1, 0, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0);
        tick();
        nop();
        chk("alu_fwd_prio", {f_fa, f_fb}, 4'b1010);

        do_reset();
        set_id(1, 9, 0, 1, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 1, 1, 4, 1, 0);
        chk("r0_no_stall", f_pc, 1);
        chk("r0_no_bubble", f_bub, 0);
        chk("r0_nof_no_stall", n_pc, 1);
        tick();
        nop();
        chk("r0_fwd", {f_fa, f_fb}, 0);

        do_reset();
        set_id(1, 1, 2, 1, 1, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 1, 1, 4, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("so_stall%0d", i), {n_pc, n_ifen, n_bub}, 3'b001);
            chk($sformatf("so_fwd%0d", i), {n_fa, n_fb}, 0);
            tick();
        end
        chk("so_release", n_pc, 1);
        chk("so_stall_cnt", n_sc, 3);
        tick();
        nop();
        chk("so_fwd_ex", {n_fa, n_fb}, 0);

        do_reset();
        set_id(1, 9, 0, 1, 0, 8, 1, 1);
        tick();
        set_id(1, 8, 11, 1, 1, 10, 1, 0);
        ex_redirect = 1;
        #1;
        chk("sim_pc_en", f_pc, 1);
        chk("sim_ifid_en", f_ifen, 1);
        chk("sim_flush", f_ifl, 1);
        chk("sim_bubble", f_bub, 1);
        tick();
        ex_redirect = 0;
        nop();
        chk("sim_flush_cnt", f_fc, 1);
        chk("sim_stall_cnt", f_sc, 0);
        ex_redirect = 1;
        #1;
        chk("b2b_flush0", f_ifl, 1);
        tick();
        chk("b2b_flush1", f_ifl, 1);
        tick();
        ex_redirect = 0;
        #1;
        chk("b2b_flush_cnt", f_fc, 3);

        do_reset();
        ex_redirect = 1;
        #1;
        tick();
        ex_redirect = 0;
        set_id(1, 9, 0, 1, 0, 8, 1, 1);
        tick();
        set_id(1, 8, 11, 1, 1, 10, 1, 0);
        chk("mid_stall", f_pc, 0);
        chk("mid_pre_fc", f_fc, 1);
        RSTn = 0;
        #1;
        chk("mid_rst_pc", f_pc, 1);
        chk("mid_rst_bub", f_bub, 0);
        chk("mid_rst_cnt", {f_sc, f_fc}, 0);
        chk("mid_rst_nof_pc", n_pc, 1);
        ex_redirect = 1;
        #1;
        chk("mid_rst_noflush", f_ifl, 0);
        ex_redirect = 0;
        nop();
        tick();
        RSTn = 1;
        ex_redirect = 1;
        #1;
        for (int i = 0; i < 5; i++) tick();
        ex_redirect = 0;
        #1;
        chk("sat_flush_cnt", s_fc, 3);
        chk("wide_flush_cnt", f_fc, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
